cg_writeback_sequencer: RTL

Datapath-side writeback sequencer for the conjugate-gradient vector memories (X, R, P). It accepts result lines from the ALU array, buffers them, and issues the write-enable, write-counter and data strobes the control unit consumes (`result_mem_we_*`, `result_mem_counter_*`). It also issues the `read_again` request that advances the operand read addresses. One instance sits in front of each vector memory's write port; it is the producer of the strobes the control unit's address logic tracks.

---
 rtl/cg_pkg.sv | 17 +
 rtl/wb_line_fifo.sv | 63 ++++++
 rtl/cg_writeback_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cg_pkg.sv
// Shared types and defaults for the CG writeback sequencer.
package cg_pkg;

    localparam int unsigned NO_OF_UNITS   = 8;
    localparam int unsigned ELEMENT_WIDTH = 64;
    localparam int unsigned LINE_WIDTH    = NO_OF_UNITS * ELEMENT_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

    typedef logic [LINE_WIDTH-1:0] line_t;

endpackage

// File: rtl/wb_line_fifo.sv
// Synchronous result-line FIFO; FIFO_DEPTH must be a power of two, at least 2.
module wb_line_fifo
    import cg_pkg::*;
#(
    parameter int unsigned Width      = $bits(line_t),
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PtrW      = $clog2(FIFO_DEPTH),
    localparam int unsigned CntW      = PtrW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic [CntW-1:0]  count,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    // Pointer and occupancy update; a simultaneous push and pop leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Pointer/count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Line storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CntW'(FIFO_DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/cg_writeback_sequencer.sv
// Writeback sequencer for one CG vector memory write port.
// Optional build macro CG_WB_OVERRUN_CHECK_EN adds a sticky `overrun` output.
module cg_writeback_sequencer
    import cg_pkg::*;
#(
    parameter int unsigned no_of_units               = NO_OF_UNITS,
    parameter int unsigned element_width             = ELEMENT_WIDTH,
    parameter int unsigned memory_read_address_width = 32,
    parameter int unsigned FIFO_DEPTH                = 4,
    localparam int unsigned LineW                    = no_of_units * element_width,
    localparam int unsigned CntW                     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [31:0]                          total,
    input  logic                                 result_valid,
    input  logic [LineW-1:0]                     result_data,
    output logic                                 result_ready,
    input  logic                                 mem_stall,
    output logic                                 result_mem_we,
    output logic [memory_read_address_width-1:0] result_mem_counter,
    output logic [LineW-1:0]                     result_mem_data,
    output logic                                 read_again,
    output logic                                 busy,
`ifdef CG_WB_OVERRUN_CHECK_EN
    output logic                                 overrun,
`endif
    output logic                                 vector_done
);

    wb_state_t state_q, state_d;
    logic [31:0] lines_q, lines_d;
    logic [31:0] accept_cnt_q, accept_cnt_d;
    logic [31:0] wr_idx_q, wr_idx_d;
    logic        we_q, we_d;
    logic        read_again_q, read_again_d;
    logic        last_q, last_d;
    logic [memory_read_address_width-1:0] counter_q, counter_d;
    logic [LineW-1:0] data_q, data_d;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [LineW-1:0] fifo_dout;
    logic [CntW-1:0]  fifo_count;

    logic active, accept, can_write, bypass, fire, is_last_idx;

    wb_line_fifo #(
        .Width      (LineW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (result_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Handshake and write-issue decode. An empty FIFO is bypassed so an accepted
    // line reaches the memory on the very next cycle.
    always_comb begin
        active       = (state_q == RUN) || (state_q == DRAIN);
        result_ready = (state_q == RUN) && (fifo_count < CntW'(FIFO_DEPTH))
                       && (accept_cnt_q < lines_q);
        accept       = result_valid && result_ready;
        can_write    = active && !mem_stall;
        fifo_pop     = can_write && !fifo_empty;
        bypass       = can_write && fifo_empty && accept;
        fifo_push    = accept && !bypass && !fifo_full;
        fire         = fifo_pop || bypass;
        is_last_idx  = (wr_idx_q == lines_q - 32'd1);
    end

    // FSM next state, counters and registered write strobes.
    always_comb begin
        state_d      = state_q;
        lines_d      = lines_q;
        accept_cnt_d = accept_cnt_q;
        wr_idx_d     = wr_idx_q;
        counter_d    = counter_q;
        data_d       = data_q;
        we_d         = fire;
        read_again_d = fire && !is_last_idx;
        last_d       = fire && is_last_idx;

        if (fire) begin
            counter_d = memory_read_address_width'(wr_idx_q);
            data_d    = fifo_empty ? result_data : fifo_dout;
            wr_idx_d  = is_last_idx ? 32'd0 : wr_idx_q + 32'd1;
        end
        if (accept) accept_cnt_d = accept_cnt_q + 32'd1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lines_d      = total / no_of_units;
                    accept_cnt_d = '0;
                    wr_idx_d     = '0;
                    counter_d    = '0;
                    state_d      = (lines_d == 32'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && (accept_cnt_q + 32'd1 == lines_q)) state_d = DRAIN;
            end
            DRAIN: begin
                // last_q marks that the write now on the port is the final line.
                if (last_q && fifo_empty) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lines_q      <= '0;
            accept_cnt_q <= '0;
            wr_idx_q     <= '0;
            counter_q    <= '0;
            data_q       <= '0;
            we_q         <= 1'b0;
            read_again_q <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lines_q      <= lines_d;
            accept_cnt_q <= accept_cnt_d;
            wr_idx_q     <= wr_idx_d;
            counter_q    <= counter_d;
            data_q       <= data_d;
            we_q         <= we_d;
            read_again_q <= read_again_d;
            last_q       <= last_d;
        end
    end

`ifdef CG_WB_OVERRUN_CHECK_EN
    logic overrun_q, overrun_d;

    // Sticky flag for lines offered when no more can be accepted.
    always_comb begin
        overrun_d = overrun_q;
        if (result_valid && (!active || (accept_cnt_q == lines_q))) overrun_d = 1'b1;
    end

    // Overrun register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) overrun_q <= 1'b0;
        else       overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`endif

    assign result_mem_we      = we_q;
    assign result_mem_counter = counter_q;
    assign result_mem_data    = data_q;
    assign read_again         = read_again_q;
    assign busy               = active;
    assign vector_done        = (state_q == DONE);

endmodule
